// File: rtl/leg4_seq.sv
// ============================================================================
// Module  : leg4_seq
// Brief   : Fetch/execute sequencer for the leg4 4-bit CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module leg4_seq #(
    parameter logic [3:0] RESET_PC     = 4'h0,
    parameter logic       RUN_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry,
    output logic       busy,
    output logic       retire
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_ADD_A = 4'h0;
    localparam logic [3:0] c_OP_MOV_AB = 4'h1;
    localparam logic [3:0] c_OP_IN_A  = 4'h2;
    localparam logic [3:0] c_OP_MOV_AI = 4'h3;
    localparam logic [3:0] c_OP_MOV_BA = 4'h4;
    localparam logic [3:0] c_OP_ADD_B = 4'h5;
    localparam logic [3:0] c_OP_IN_B  = 4'h6;
    localparam logic [3:0] c_OP_MOV_BI = 4'h7;
    localparam logic [3:0] c_OP_OUT_B = 4'h9;
    localparam logic [3:0] c_OP_OUT_I = 4'hB;
    localparam logic [3:0] c_OP_JNC   = 4'hE;
    localparam logic [3:0] c_OP_JMP   = 4'hF;

    state_t     r_state;
    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_c;
    logic [3:0] r_out;
    logic       r_retire;
    logic       r_run_ovr;

    logic       w_run;
    logic [3:0] w_op;
    logic [3:0] w_im;
    logic [4:0] w_sum_a;
    logic [4:0] w_sum_b;
    logic [3:0] w_pc_inc;

    // Until run is first seen low, RUN_ON_RESET forces free-run behaviour.
    assign w_run    = run | r_run_ovr;
    assign w_op     = r_ir[7:4];
    assign w_im     = r_ir[3:0];
    assign w_sum_a  = {1'b0, r_a} + {1'b0, w_im};
    assign w_sum_b  = {1'b0, r_b} + {1'b0, w_im};
    assign w_pc_inc = r_pc + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 8'h00;
            r_a       <= 4'h0;
            r_b       <= 4'h0;
            r_c       <= 1'b0;
            r_out     <= 4'h0;
            r_retire  <= 1'b0;
            r_run_ovr <= RUN_ON_RESET;
        end else begin
            r_retire <= 1'b0;
            if (!run) begin
                r_run_ovr <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_run || step) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= rom_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_retire <= 1'b1;
                    r_c      <= 1'b0;
                    r_pc     <= w_pc_inc;
                    case (w_op)
                        c_OP_ADD_A: begin
                            r_a <= w_sum_a[3:0];
                            r_c <= w_sum_a[4];
                        end
                        c_OP_MOV_AB: r_a <= r_b;
                        c_OP_IN_A:   r_a <= in_port;
                        c_OP_MOV_AI: r_a <= w_im;
                        c_OP_MOV_BA: r_b <= r_a;
                        c_OP_ADD_B: begin
                            r_b <= w_sum_b[3:0];
                            r_c <= w_sum_b[4];
                        end
                        c_OP_IN_B:   r_b <= in_port;
                        c_OP_MOV_BI: r_b <= w_im;
                        c_OP_OUT_B:  r_out <= r_b;
                        c_OP_OUT_I:  r_out <= w_im;
                        // JNC tests the carry left by the previous instruction.
                        c_OP_JNC: begin
                            if (!r_c) begin
                                r_pc <= w_im;
                            end
                        end
                        c_OP_JMP:    r_pc <= w_im;
                        default: begin
                        end
                    endcase
                    r_state <= w_run ? S_FETCH : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign out_port = r_out;
    assign reg_a    = r_a;
    assign reg_b    = r_b;
    assign carry    = r_c;
    assign busy     = (r_state != S_IDLE);
    assign retire   = r_retire;

endmodule

`default_nettype wire

// File: doc/leg4_seq.md
Name: leg4_seq

Overview:
- Fetch/execute sequencer for the leg4 4-bit CPU.
- Drives the address of the 16x8 program ROM and latches each byte into an instruction register. Executes the instruction against registers A, B, carry flag C and a 4-bit output port.
- Sits between the program ROM and board I/O (switches to in_port, LEDs from out_port).
- Supports free-run and single-step operation.

Parameters:
RESET_PC, 4'h0, PC value loaded on reset
RUN_ON_RESET, 1'b0, if 1 the sequencer behaves as if run=1 until run is first sampled low

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  level: 1 = execute continuously
step  in  1  one-cycle pulse: execute exactly one instruction while run=0
rom_addr  out  4  program ROM address (= PC)
rom_data  in  8  ROM byte, combinational from rom_addr; [7:4] opcode, [3:0] immediate Im
in_port  in  4  input switches
out_port  out  4  registered output port
reg_a  out  4  register A (debug)
reg_b  out  4  register B (debug)
carry  out  1  carry flag C
busy  out  1  high in FETCH and EXEC
retire  out  1  one-cycle pulse in the cycle after an EXEC commit

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, PC=RESET_PC, IR=0, A=B=0, C=0, out_port=0, retire=0. Reset during FETCH/EXEC aborts the instruction with no partial commit.
- States:
  - IDLE: go to FETCH if run=1, or if step=1 (with run=0). Otherwise stay.
  - FETCH: IR<=rom_data (rom_addr=PC). Go to EXEC.
  - EXEC: commit per opcode table, retire<=1 next cycle. Next state is FETCH if run=1, else IDLE.
- Two cycles per instruction in run mode; retire pulses every 2nd cycle.
- step is ignored while busy=1. run falling mid-instruction completes the current instruction, then returns to IDLE.
- All arithmetic is 4-bit. C is the carry-out of the 4-bit add. Every EXEC writes C: the add result for ADD, 0 for all other opcodes.
- Unless the opcode is a taken jump, PC<=PC+1 mod 16 (0xF wraps to 0x0).
- Opcode table (op: action):
  - 0 ADD A,Im: A<=A+Im
  - 1 MOV A,B: A<=B
  - 2 IN A: A<=in_port
  - 3 MOV A,Im: A<=Im
  - 4 MOV B,A: B<=A
  - 5 ADD B,Im: B<=B+Im
  - 6 IN B: B<=in_port
  - 7 MOV B,Im: B<=Im
  - 9 OUT B: out_port<=B
  - B OUT Im: out_port<=Im
  - E JNC Im: if C==0 (value before this EXEC) PC<=Im, else PC+1
  - F JMP Im: PC<=Im
  - 8, A, C, D: NOP
- in_port is sampled in the EXEC cycle.
- out_port changes only on OUT instructions.

Test Plan:
- Reset: hold rst_n=0 2 cycles while in run mode, mid-EXEC of ADD A,8 -> A=B=C=0, out_port=0, rom_addr=RESET_PC, busy=0; A must not update.
- Program 20,08,E8,B1,B2,B4,B8,F0,B8,B4,B2,B1,F0, in_port=9, run=1 -> A=9, then A=1 C=1, JNC not taken. out_port sequence 1,2,4,8, then rom_addr returns to 0; retire every 2 cycles.
- Same program, in_port=0 -> A=8 C=0, JNC taken to 8. out_port sequence 8,4,2,1, then JMP 0.
- Step mode: run=0, single step pulses -> exactly one retire per pulse and PC+1 each. A step asserted during FETCH/EXEC produces no extra instruction.
- Carry/wrap: MOV B,F then ADD B,1 -> B=0 C=1, next MOV A,1 clears C. NOP at PC=F -> rom_addr=0.
- Run drop: deassert run during FETCH -> the instruction completes, state returns to IDLE, busy=0, PC is held.
